// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the BCD-to-binary peripheral: register map,
// widths, FSM encoding and per-nibble helper functions.
package bcd2bin_pkg;

   localparam int DIGITS = 4;           // BCD digits per operand
   localparam int BCD_W  = 4 * DIGITS;  // packed operand width (16)
   localparam int BIN_W  = 14;          // result width; 9999 fits in 14 bits
   localparam int ADDR_W = 5;           // bus address width
   localparam int DATA_W = 16;          // bus data width
   localparam int STEPS  = 16;          // one shift per operand bit
   localparam int CNT_W  = 5;           // holds 0..STEPS

   localparam logic [ADDR_W-1:0] ADDR_DATA   = 5'h04;
   localparam logic [ADDR_W-1:0] ADDR_INIT   = 5'h08;
   localparam logic [ADDR_W-1:0] ADDR_RESULT = 5'h0C;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'h10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // True when any nibble of the packed operand is not a decimal digit.
   function automatic logic bcd_invalid(input logic [BCD_W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

   // Reverse double-dabble correction: every nibble that reads 8 or more
   // after the right shift held a carried-in 10 (seen as 8), so take 3 away.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd8) begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd2bin_core.sv
// Iterative BCD-to-binary engine. A start pulse snapshots the operand;
// sixteen right shifts of {bcd, bin} with per-nibble correction leave the
// binary value in bin. Invalid operands finish one clock after start with
// err set and a zero result.
module bcd2bin_core
   import bcd2bin_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [BCD_W-1:0] bcd_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [BIN_W-1:0] bin_out,
   output state_t           state
);

   state_t              state_next;
   logic [BCD_W-1:0]    bcd_q;
   logic [BCD_W-1:0]    bin_q;      // full 16 bits so the last shift lands the LSB at bit 0
   logic [CNT_W-1:0]    count_q;
   logic                bad_q;
   logic [BIN_W-1:0]    result_q;

   logic [2*BCD_W-1:0]  shifted;
   logic [BCD_W-1:0]    bcd_next;
   logic [BCD_W-1:0]    bin_next;
   logic                last_step;

   // One iteration of the shift-and-correct datapath.
   always_comb begin
      shifted   = {bcd_q, bin_q} >> 1;
      bcd_next  = bcd_adjust(shifted[2*BCD_W-1:BCD_W]);
      bin_next  = shifted[BCD_W-1:0];
      last_step = (count_q == CNT_W'(STEPS - 1));
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: start wins from every state, so INIT mid-run restarts.
   always_comb begin
      state_next = state;
      if (start) begin
         state_next = SHIFT;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            SHIFT:   if (bad_q || last_step) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Datapath, counter and result/flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcd_q    <= '0;
         bin_q    <= '0;
         count_q  <= '0;
         bad_q    <= 1'b0;
         result_q <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else if (start) begin
         bcd_q    <= bcd_in;
         bin_q    <= '0;
         count_q  <= '0;
         bad_q    <= bcd_invalid(bcd_in);
         result_q <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else if (state == SHIFT) begin
         if (bad_q) begin
            // Rejected operand: report after a single clock, no shifting.
            result_q <= '0;
            done     <= 1'b1;
            err      <= 1'b1;
         end else begin
            bcd_q   <= bcd_next;
            bin_q   <= bin_next;
            count_q <= count_q + CNT_W'(1);
            if (last_step) begin
               result_q <= bin_next[BIN_W-1:0];
               done     <= 1'b1;
            end
         end
      end
   end

   assign busy    = (state == SHIFT);
   assign bin_out = result_q;

endmodule

// File: rtl/peripheral_bcd2bin.sv
// Bus-facing wrapper for the BCD-to-binary engine: address decode, the
// DATA operand register, INIT start pulse and the registered read port.
module peripheral_bcd2bin
   import bcd2bin_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] d_in,
   input  logic              cs,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   output logic [DATA_W-1:0] d_out
);

   // Bus strobes: a transfer happens on every posedge where cs is high with
   // wr and/or rd; there is no wait state. A write lands at that edge; a read
   // captures the register's pre-edge value into d_out, valid the next cycle.
   // Both strobes together perform the write and return the old value.

   logic              wr_en;
   logic              rd_en;
   logic              data_we;
   logic              start;
   logic [BCD_W-1:0]  data_q;
   logic [DATA_W-1:0] rd_mux;

   logic              core_busy;
   logic              core_done;
   logic              core_err;
   logic [BIN_W-1:0]  core_bin;
   state_t            core_state;

   assign wr_en   = cs & wr;
   assign rd_en   = cs & rd;
   assign data_we = wr_en & (addr == ADDR_DATA);
   assign start   = wr_en & (addr == ADDR_INIT) & d_in[0];

   // Operand register; the engine keeps its own snapshot once started.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
      end else if (data_we) begin
         data_q <= d_in[BCD_W-1:0];
      end
   end

   bcd2bin_core u_core (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bcd_in  (data_q),
      .busy    (core_busy),
      .done    (core_done),
      .err     (core_err),
      .bin_out (core_bin),
      .state   (core_state)
   );

   // Readable registers; write-only and unmapped addresses read as zero.
   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_RESULT: rd_mux = {{(DATA_W-BIN_W){1'b0}}, core_bin};
         ADDR_STATUS: rd_mux = {{(DATA_W-2){1'b0}}, core_err, core_done};
         default:     rd_mux = '0;
      endcase
   end

   // Registered read port: cleared on any cycle without a read strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_out <= '0;
      end else if (rd_en) begin
         d_out <= rd_mux;
      end else begin
         d_out <= '0;
      end
   end

   // done is only ever high while the engine sits in DONE, never while shifting.
   assert property (@(posedge clk) disable iff (reset) (core_state == DONE) |-> core_done);
   assert property (@(posedge clk) disable iff (reset) core_busy |-> !core_done);

endmodule

// File: tb/tb_peripheral_bcd2bin.sv
// Directed bench for peripheral_bcd2bin: a decimal-arithmetic model tracks
// DATA/RESULT/STATUS and predicts d_out every cycle, alongside literal checks.
module tb_peripheral_bcd2bin;

   localparam logic [4:0] A_DATA   = 5'h04;
   localparam logic [4:0] A_INIT   = 5'h08;
   localparam logic [4:0] A_RESULT = 5'h0C;
   localparam logic [4:0] A_STATUS = 5'h10;

   // ---------------- clock / reset ----------------
   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] d_in  = '0;
   logic        cs    = 1'b0;
   logic [4:0]  addr  = '0;
   logic        rd    = 1'b0;
   logic        wr    = 1'b0;
   logic [15:0] d_out;

   always #5 clk = ~clk;

   peripheral_bcd2bin dut (
      .clk   (clk),
      .reset (reset),
      .d_in  (d_in),
      .cs    (cs),
      .addr  (addr),
      .rd    (rd),
      .wr    (wr),
      .d_out (d_out)
   );

   int n_total = 0;
   int n_bad   = 0;
   bit chk_en  = 1'b0;

   // ---------------- behavioural model ----------------
   function automatic int bcd_value(input logic [15:0] v);
      return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
   endfunction

   function automatic bit bcd_bad(input logic [15:0] v);
      return (v[15:12] > 9) || (v[11:8] > 9) || (v[7:4] > 9) || (v[3:0] > 9);
   endfunction

   logic [15:0] m_data     = '0;
   logic        m_done     = 1'b0;
   logic        m_err      = 1'b0;
   logic [13:0] m_result   = '0;
   int          m_left     = 0;   // clocks until the pending conversion reports
   logic        m_pend_err = 1'b0;
   logic [13:0] m_pend_val = '0;
   logic [15:0] exp_dout   = '0;

   initial begin
      logic [15:0] rv;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_data = '0; m_done = 1'b0; m_err = 1'b0; m_result = '0;
            m_left = 0; exp_dout = '0;
         end else begin
            case (addr)
               A_RESULT: rv = {2'b00, m_result};
               A_STATUS: rv = {14'd0, m_err, m_done};
               default:  rv = '0;
            endcase
            exp_dout = (cs && rd) ? rv : 16'h0000;
            if (m_left > 0) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_done   = 1'b1;
                  m_err    = m_pend_err;
                  m_result = m_pend_err ? 14'd0 : m_pend_val;
               end
            end
            if (cs && wr && addr == A_DATA) m_data = d_in;
            if (cs && wr && addr == A_INIT && d_in[0]) begin
               m_pend_err = bcd_bad(m_data);
               m_pend_val = 14'(bcd_value(m_data));
               m_done = 1'b0; m_err = 1'b0; m_result = '0;
               m_left = m_pend_err ? 1 : 16;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // Per-cycle compare of d_out against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            exp_q.push_back(exp_dout);
            check($sformatf("dout_cycle@%0t", $time), d_out, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus_write(input logic [4:0] a, input logic [15:0] v);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = v;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [15:0] v);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
      @(negedge clk);
      v = d_out;
      cs = 1'b0; rd = 1'b0; addr = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic convert(input logic [15:0] v);
      bus_write(A_DATA, v);
      bus_write(A_INIT, 16'h0001);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [15:0] r;

      // model pins
      check("model_1234", 16'(bcd_value(16'h1234)), 16'd1234);
      check("model_9999", 16'(bcd_value(16'h9999)), 16'h270F);
      check("model_bad",  16'(bcd_bad(16'h12A4)), 16'd1);

      #1 reset = 1'b1;
      idle(3);
      reset = 1'b0;
      chk_en = 1'b1;
      check("reset_dout", d_out, 16'h0000);
      bus_read(A_STATUS, r); check("reset_status", r, 16'h0000);
      bus_read(A_RESULT, r); check("reset_result", r, 16'h0000);

      // 1: 1234 -> 04D2, done not before E16
      convert(16'h1234);
      idle(15);
      bus_read(A_STATUS, r); check("t1_status_e15", r, 16'h0000);
      bus_read(A_STATUS, r); check("t1_status_e16", r, 16'h0001);
      bus_read(A_RESULT, r); check("t1_result", r, 16'h04D2);
      bus_write(A_INIT, 16'h0000);
      bus_read(A_STATUS, r); check("t1_init0_ignored", r, 16'h0001);
      bus_read(5'h14, r);    check("t1_unmapped", r, 16'h0000);
      bus_read(A_DATA, r);   check("t1_data_wo", r, 16'h0000);

      // 2: extremes
      convert(16'h9999);
      idle(16);
      bus_read(A_RESULT, r); check("t2_result_9999", r, 16'h270F);
      convert(16'h0000);
      idle(15);
      bus_read(A_STATUS, r); check("t2_status_e15", r, 16'h0000);
      bus_read(A_STATUS, r); check("t2_status_e16", r, 16'h0001);
      bus_read(A_RESULT, r); check("t2_result_0", r, 16'h0000);

      // 3: invalid digit
      convert(16'h12A4);
      bus_read(A_STATUS, r); check("t3_status_e0", r, 16'h0000);
      bus_read(A_STATUS, r); check("t3_status_e1", r, 16'h0003);
      bus_read(A_RESULT, r); check("t3_result", r, 16'h0000);

      // 4: poll STATUS every cycle
      convert(16'h0500);
      cs = 1'b1; rd = 1'b1; addr = A_STATUS;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check($sformatf("t4_poll_%0d", k), d_out, (k >= 17) ? 16'h0001 : 16'h0000);
      end
      cs = 1'b0; rd = 1'b0; addr = '0;
      bus_read(A_RESULT, r); check("t4_result", r, 16'h01F4);

      // 5: restart at E5 with new operand
      convert(16'h0042);
      idle(3);
      bus_write(A_DATA, 16'h0777);
      bus_write(A_INIT, 16'h0001);
      idle(15);
      bus_read(A_STATUS, r); check("t5_status_e15", r, 16'h0000);
      bus_read(A_STATUS, r); check("t5_status_e16", r, 16'h0001);
      bus_read(A_RESULT, r); check("t5_result", r, 16'h0309);

      // 6: reset mid-conversion, then a fresh conversion
      convert(16'h5678);
      idle(7);
      #1 reset = 1'b1;
      @(negedge clk);
      check("t6_dout_reset", d_out, 16'h0000);
      reset = 1'b0;
      bus_read(A_STATUS, r); check("t6_status", r, 16'h0000);
      bus_read(A_RESULT, r); check("t6_result", r, 16'h0000);
      convert(16'h0100);
      idle(16);
      bus_read(A_STATUS, r); check("t6_status_done", r, 16'h0001);
      bus_read(A_RESULT, r); check("t6_result_0100", r, 16'h0064);

      // 7: reset while d_out holds a result; DATA also clears
      cs = 1'b1; rd = 1'b1; addr = A_RESULT;
      @(negedge clk);
      check("t7_dout_before", d_out, 16'h0064);
      #1 reset = 1'b1;
      #1 check("t7_dout_async", d_out, 16'h0000);
      cs = 1'b0; rd = 1'b0; addr = '0;
      @(negedge clk);
      reset = 1'b0;
      bus_write(A_INIT, 16'h0001);
      idle(16);
      bus_read(A_STATUS, r); check("t7_status", r, 16'h0001);
      bus_read(A_RESULT, r); check("t7_result_zero_data", r, 16'h0000);

      idle(2);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
